vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator.
- Replaces the paired horizontal/vertical counters with one block holding both counters, sync generation, the active-video flag, pixel coordinates and frame/line strobes.
- Sits between the pixel-clock enable source and the pixel pipeline / VGA DAC.
- Default parameters give 640x480@60 (800x525 total).

---
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Holds the horizontal and vertical counters and produces registered sync,
// active-video, pixel coordinates and line/frame strobes. The outputs are
// registered from the pre-update counter values, so they trail the counters
// by one clock. h_tc is combinational and is meant for chaining.

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_end,
    output logic          frame_end,
    output logic          h_tc
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // A counter that cannot reach TOTAL-1 would never wrap correctly.
    if ((H_TOTAL - 1) > ((1 << CW) - 1)) begin : g_h_too_wide
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
    end
    if ((V_TOTAL - 1) > ((1 << CW) - 1)) begin : g_v_too_wide
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
    end

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

    // Region bounds are one bit wider so a sync ending exactly at 2^CW
    // (zero back porch at full counter range) still compares correctly.
    localparam logic [CW:0] H_ACT_END = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] HS_BEG    = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END    = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_END = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] VS_BEG    = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END    = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_on_q, video_on_d;
    logic          line_end_q, line_end_d;
    logic          frame_end_q, frame_end_d;

    logic          h_last;
    logic          v_last;
    logic [CW:0]   h_ext;
    logic [CW:0]   v_ext;

    assign h_last = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);
    assign h_ext  = {1'b0, h_cnt_q};
    assign v_ext  = {1'b0, v_cnt_q};
    assign h_tc   = en & h_last;

    // Next counter values: h advances on every enable, v only at end of line.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (en) begin
            if (h_last) begin
                h_cnt_d = '0;
                if (v_last) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Output decode from the current (pre-update) counters; strobes need en.
    always_comb begin
        x_d         = h_cnt_q;
        y_d         = v_cnt_q;
        video_on_d  = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
        hsync_d     = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
        vsync_d     = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
        line_end_d  = en & h_last;
        frame_end_d = en & h_last & v_last;
    end

    // State and output registers; reset takes priority over en.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            hsync_q     <= ~HS_POL;
            vsync_q     <= ~VS_POL;
            video_on_q  <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign x         = x_q;
    assign y         = y_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives a default 640x480 instance and a small
// positive-polarity instance from the same clock/en/reset and compares every
// output against a reference built from the count of enabled clocks.

module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;

    always #5 clk = ~clk;

    // Default-parameter instance
    logic       d_hs, d_vs, d_von, d_le, d_fe, d_tc;
    logic [9:0] d_x, d_y;

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .en(en),
        .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .x(d_x), .y(d_y), .line_end(d_le), .frame_end(d_fe), .h_tc(d_tc)
    );

    // Small instance: 16 x 8 raster, active-high syncs
    logic       s_hs, s_vs, s_von, s_le, s_fe, s_tc;
    logic [4:0] s_x, s_y;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(5)
    ) u_small (
        .clk(clk), .reset(reset), .en(en),
        .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .x(s_x), .y(s_y), .line_end(s_le), .frame_end(s_fe), .h_tc(s_tc)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        von;
        logic [31:0] x;
        logic [31:0] y;
        logic        le;
        logic        fe;
    } exp_t;

    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb;
        bit hp, vp;
    } cfg_t;

    cfg_t cfg_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg_t cfg_s = '{8, 2, 3, 3, 4, 1, 1, 2, 1'b1, 1'b1};

    // Enabled clocks since reset; the raster position follows from it.
    longint n = 0;
    bit     known = 0;

    // Strobe spacing measured in enabled clocks
    longint en_clks = 0;
    longint last_fe_s = -1;
    longint last_le_d = -1;

    function automatic exp_t model(cfg_t c, longint cnt, bit e);
        exp_t r;
        int ht, vt, h, v;
        ht = c.ha + c.hf + c.hsw + c.hb;
        vt = c.va + c.vf + c.vsw + c.vb;
        h  = int'(cnt % ht);
        v  = int'((cnt / ht) % vt);
        r.x   = h;
        r.y   = v;
        r.von = (h < c.ha) && (v < c.va);
        r.hs  = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hp : !c.hp;
        r.vs  = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vp : !c.vp;
        r.le  = e && (h == ht - 1);
        r.fe  = r.le && (v == vt - 1);
        return r;
    endfunction

    function automatic exp_t reset_exp(cfg_t c);
        exp_t r;
        r.x = 0; r.y = 0; r.von = 1'b0; r.le = 1'b0; r.fe = 1'b0;
        r.hs = !c.hp; r.vs = !c.vp;
        return r;
    endfunction

    function automatic logic tc_model(cfg_t c, longint cnt, bit e);
        int ht;
        ht = c.ha + c.hf + c.hsw + c.hb;
        return e && ((cnt % ht) == ht - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: apply en/reset, check h_tc, advance, check registered outputs.
    task automatic step(input bit e, input bit r);
        exp_t ed, es;
        en = e;
        reset = r;
        #1;
        if (known) begin
            chk("def_h_tc", 32'(d_tc), 32'(tc_model(cfg_d, n, e)));
            chk("sml_h_tc", 32'(s_tc), 32'(tc_model(cfg_s, n, e)));
        end
        @(posedge clk);
        if (r) begin
            ed = reset_exp(cfg_d);
            es = reset_exp(cfg_s);
            n = 0;
            known = 1;
            last_fe_s = -1;
            last_le_d = -1;
        end else begin
            ed = model(cfg_d, n, e);
            es = model(cfg_s, n, e);
            if (e) begin
                n++;
                en_clks++;
            end
        end
        @(negedge clk);
        chk("def_x", 32'(d_x), ed.x);
        chk("def_y", 32'(d_y), ed.y);
        chk("def_video_on", 32'(d_von), 32'(ed.von));
        chk("def_hsync", 32'(d_hs), 32'(ed.hs));
        chk("def_vsync", 32'(d_vs), 32'(ed.vs));
        chk("def_line_end", 32'(d_le), 32'(ed.le));
        chk("def_frame_end", 32'(d_fe), 32'(ed.fe));
        chk("sml_x", 32'(s_x), es.x);
        chk("sml_y", 32'(s_y), es.y);
        chk("sml_video_on", 32'(s_von), 32'(es.von));
        chk("sml_hsync", 32'(s_hs), 32'(es.hs));
        chk("sml_vsync", 32'(s_vs), 32'(es.vs));
        chk("sml_line_end", 32'(s_le), 32'(es.le));
        chk("sml_frame_end", 32'(s_fe), 32'(es.fe));
        if (!r && s_fe === 1'b1) begin
            if (last_fe_s >= 0) chk("sml_frame_period", 32'(en_clks - last_fe_s), 32'd128);
            last_fe_s = en_clks;
        end
        if (!r && d_le === 1'b1) begin
            if (last_le_d >= 0) chk("def_line_period", 32'(en_clks - last_le_d), 32'd800);
            last_le_d = en_clks;
        end
    endtask

    initial begin
        @(negedge clk);

        // Reset held for three clocks with en high
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

        // Continuous enable: two full default lines, many small frames
        for (int i = 0; i < 1700; i++) step(1'b1, 1'b0);

        // Divide-by-2 enable pulse train
        for (int i = 0; i < 1800; i++) step(i[0] == 1'b0, 1'b0);

        // Random enable density
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0, 1'b0);

        // Reset mid-line at default x=300
        for (int i = 0; i < 800 && (n % 800) != 300; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 900; i++) step(1'b1, 1'b0);

        // Enable held low: outputs static, no strobes
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0);

        // Random enable with occasional reset pulses
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
